// File: rtl/div32_seq.sv
`default_nettype none
// ============================================================================
// Module      : div32_seq
// Description : Sequential signed restoring divider for the ALU DIV path.
//               Each launch runs WIDTH trial-subtract steps on the operand
//               magnitudes, then applies the signs in a final fix-up cycle.
//               The quotient (LO) truncates toward zero. The remainder (HI)
//               takes the sign of the dividend.
//
// Ports       : clk         - system clock, rising edge
//               clr         - asynchronous active-low reset
//               start       - launch request, sampled only while idle
//               dividend    - signed dividend, sampled on the accepting edge
//               divisor     - signed divisor, sampled on the accepting edge
//               busy        - operation in progress (state != IDLE)
//               done        - one-cycle pulse, results valid
//               quotient    - signed quotient (LO)
//               remainder   - signed remainder (HI)
//               div_by_zero - divisor was zero; held until the next done
//
// Revision    : 1.0 - initial release
// ============================================================================
module div32_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int                c_cnt_w    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_next;

    logic [c_cnt_w-1:0]  r_count;
    // The partial remainder is always below M (M <= 2^(WIDTH-1)), so WIDTH
    // bits hold it. Only the shifted value needs the extra bit, and that bit
    // is carried in the 33-bit trial subtraction below.
    logic [WIDTH-1:0]    r_a;
    logic [WIDTH-1:0]    r_q;
    logic [WIDTH-1:0]    r_m;
    logic                r_qsign;
    logic                r_rsign;
    logic                r_dbz;

    logic                r_done;
    logic [WIDTH-1:0]    r_quotient;
    logic [WIDTH-1:0]    r_remainder;
    logic                r_div_by_zero;

    logic                w_divisor_zero;
    logic [WIDTH-1:0]    w_dividend_abs;
    logic [WIDTH-1:0]    w_divisor_abs;
    logic [WIDTH:0]      w_a_sh;
    logic [WIDTH-1:0]    w_q_sh;
    logic [WIDTH:0]      w_t;

    // Operand magnitudes use plain two's-complement negation. The most
    // negative value maps onto itself, and it is correct when that result is
    // read as unsigned.
    assign w_divisor_zero = (divisor == '0);
    assign w_dividend_abs = dividend[WIDTH-1] ? (~dividend + 1'b1) : dividend;
    assign w_divisor_abs  = divisor[WIDTH-1]  ? (~divisor  + 1'b1) : divisor;

    // One restoring step: shift {A,Q} left, then try A - M with a borrow-out.
    assign w_a_sh = {r_a, r_q[WIDTH-1]};
    assign w_q_sh = {r_q[WIDTH-2:0], 1'b0};
    assign w_t    = w_a_sh - {1'b0, r_m};

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = w_divisor_zero ? S_FIX : S_CALC;
                end
            end
            S_CALC: begin
                if (r_count == c_cnt_last) begin
                    w_state_next = S_FIX;
                end
            end
            S_FIX: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_count       <= '0;
            r_a           <= '0;
            r_q           <= '0;
            r_m           <= '0;
            r_qsign       <= 1'b0;
            r_rsign       <= 1'b0;
            r_dbz         <= 1'b0;
            r_done        <= 1'b0;
            r_quotient    <= '0;
            r_remainder   <= '0;
            r_div_by_zero <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_count <= '0;
                        if (w_divisor_zero) begin
                            // Hold the raw dividend in Q so that the fix-up
                            // cycle can return it as the remainder.
                            r_dbz <= 1'b1;
                            r_q   <= dividend;
                        end else begin
                            r_dbz   <= 1'b0;
                            r_q     <= w_dividend_abs;
                            r_m     <= w_divisor_abs;
                            r_a     <= '0;
                            r_qsign <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                            r_rsign <= dividend[WIDTH-1];
                        end
                    end
                end
                S_CALC: begin
                    // A borrow means A < M. Keep the shifted A (restore) and
                    // shift a 0 into the quotient.
                    r_a     <= w_t[WIDTH] ? w_a_sh[WIDTH-1:0] : w_t[WIDTH-1:0];
                    r_q     <= {w_q_sh[WIDTH-1:1], ~w_t[WIDTH]};
                    r_count <= r_count + 1'b1;
                end
                S_FIX: begin
                    r_done <= 1'b1;
                    if (r_dbz) begin
                        r_quotient    <= '1;
                        r_remainder   <= r_q;
                        r_div_by_zero <= 1'b1;
                    end else begin
                        r_quotient    <= r_qsign ? (~r_q + 1'b1) : r_q;
                        r_remainder   <= r_rsign ? (~r_a + 1'b1) : r_a;
                        r_div_by_zero <= 1'b0;
                    end
                end
                default: begin
                    r_count <= '0;
                end
            endcase
        end
    end

    assign busy        = (r_state != S_IDLE);
    assign done        = r_done;
    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign div_by_zero = r_div_by_zero;

endmodule
`default_nettype wire
